// File: rtl/cache_bank_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// cache_bank_rr_arbiter_if
// Bundles the requester side and the bank side of one cache-bank arbiter.
//   Req / Req_Addr            requester levels and packed addresses
//   Rsp_Ack / Rsp_Err / Rsp_Data   one-hot completion pulse, error flag, data
//   Bank_Req / Bank_Addr      single-cycle request and address to the bank
//   Bank_Ack / Bank_Data      bank completion pulse and read data
//   Busy / Gnt_Idx            status: transaction in flight, current/last grant
// Modports:
//   slave  - the arbiter itself (serves requesters, drives the bank)
//   master - the surrounding environment (requesters plus bank)
// ---------------------------------------------------------------------------
interface cache_bank_rr_arbiter_if #(
   parameter int N_REQ  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int GNT_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0]        Req;
   logic [N_REQ*ADDR_W-1:0] Req_Addr;
   logic [N_REQ-1:0]        Rsp_Ack;
   logic                    Rsp_Err;
   logic [DATA_W-1:0]       Rsp_Data;
   logic                    Bank_Req;
   logic [ADDR_W-1:0]       Bank_Addr;
   logic                    Bank_Ack;
   logic [DATA_W-1:0]       Bank_Data;
   logic                    Busy;
   logic [GNT_W-1:0]        Gnt_Idx;

   modport slave (
      input  Req, Req_Addr, Bank_Ack, Bank_Data,
      output Rsp_Ack, Rsp_Err, Rsp_Data, Bank_Req, Bank_Addr, Busy, Gnt_Idx
   );

   modport master (
      output Req, Req_Addr, Bank_Ack, Bank_Data,
      input  Rsp_Ack, Rsp_Err, Rsp_Data, Bank_Req, Bank_Addr, Busy, Gnt_Idx
   );
endinterface

// File: rtl/cache_bank_rr_arbiter.sv
// ---------------------------------------------------------------------------
// cache_bank_rr_arbiter
// Shares one cache bank port among N_REQ requesters with round-robin
// arbitration and a single outstanding transaction. A granted request is
// issued to the bank as a one-cycle pulse; the bank's Ack (or a timeout after
// TIMEOUT wait cycles) is turned into a one-cycle response to the requester.
// Ports:
//   CLK   - clock, all state on the rising edge
//   RSTn  - asynchronous active-low reset
//   bus   - cache_bank_rr_arbiter_if.slave (requester and bank signals)
// All outputs are driven straight from registers.
// ---------------------------------------------------------------------------
module cache_bank_rr_arbiter #(
   parameter int N_REQ   = 4,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 8
) (
   input  logic                     CLK,
   input  logic                     RSTn,
   cache_bank_rr_arbiter_if.slave   bus
);

   localparam int GNT_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   localparam logic [GNT_W-1:0] RR_RESET = GNT_W'(N_REQ - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t              state_r,     state_nxt_s;
   logic [CNT_W-1:0]    cnt_r,       cnt_nxt_s;
   logic [GNT_W-1:0]    rr_last_r,   rr_last_nxt_s;
   logic [GNT_W-1:0]    gnt_idx_r,   gnt_idx_nxt_s;
   logic                bank_req_r,  bank_req_nxt_s;
   logic [ADDR_W-1:0]   bank_addr_r, bank_addr_nxt_s;
   logic [N_REQ-1:0]    rsp_ack_r,   rsp_ack_nxt_s;
   logic                rsp_err_r,   rsp_err_nxt_s;
   logic [DATA_W-1:0]   rsp_data_r,  rsp_data_nxt_s;
   logic                busy_r,      busy_nxt_s;

   logic                pick_found_s;
   logic [GNT_W-1:0]    pick_idx_s;

   // Round-robin search: first set request starting just after the last
   // winner and wrapping. Returns {found, index}.
   function automatic logic [GNT_W:0] rr_pick(
      input logic [N_REQ-1:0] req,
      input logic [GNT_W-1:0] last
   );
      logic             found;
      logic [GNT_W-1:0] idx;
      logic [GNT_W-1:0] pos;
      found = 1'b0;
      idx   = {GNT_W{1'b0}};
      for (int k = 1; k <= N_REQ; k++) begin
         pos = GNT_W'((int'(last) + k) % N_REQ);
         if (!found && req[pos]) begin
            found = 1'b1;
            idx   = pos;
         end else begin
            idx   = idx;
         end
      end
      return {found, idx};
   endfunction

   // Arbitration candidate for the next IDLE edge.
   always_comb begin
      {pick_found_s, pick_idx_s} = rr_pick(bus.Req, rr_last_r);
   end

   // Next-state and next-output logic of the IDLE -> WAIT -> DONE sequencer.
   always_comb begin
      state_nxt_s     = state_r;
      cnt_nxt_s       = cnt_r;
      rr_last_nxt_s   = rr_last_r;
      gnt_idx_nxt_s   = gnt_idx_r;
      bank_req_nxt_s  = 1'b0;
      bank_addr_nxt_s = bank_addr_r;
      rsp_ack_nxt_s   = {N_REQ{1'b0}};
      rsp_err_nxt_s   = 1'b0;
      rsp_data_nxt_s  = rsp_data_r;

      case (state_r)
         ST_IDLE: begin
            if (pick_found_s) begin
               gnt_idx_nxt_s   = pick_idx_s;
               rr_last_nxt_s   = pick_idx_s;
               bank_addr_nxt_s = bus.Req_Addr[int'(pick_idx_s)*ADDR_W +: ADDR_W];
               bank_req_nxt_s  = 1'b1;
               cnt_nxt_s       = {CNT_W{1'b0}};
               state_nxt_s     = ST_WAIT;
            end else begin
               state_nxt_s     = ST_IDLE;
            end
         end
         ST_WAIT: begin
            // Ack takes precedence over a coinciding timeout.
            if (bus.Bank_Ack) begin
               rsp_ack_nxt_s[gnt_idx_r] = 1'b1;
               rsp_data_nxt_s           = bus.Bank_Data;
               rsp_err_nxt_s            = 1'b0;
               state_nxt_s              = ST_DONE;
            end else if (cnt_r == CNT_LAST) begin
               rsp_ack_nxt_s[gnt_idx_r] = 1'b1;
               rsp_data_nxt_s           = {DATA_W{1'b0}};
               rsp_err_nxt_s            = 1'b1;
               state_nxt_s              = ST_DONE;
            end else begin
               cnt_nxt_s                = cnt_r + CNT_W'(1);
            end
         end
         ST_DONE: begin
            // Turnaround cycle: no arbitration so the served requester can drop Req.
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase

      busy_nxt_s = (state_nxt_s != ST_IDLE);
   end

   // State and output registers.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_r     <= ST_IDLE;
         cnt_r       <= {CNT_W{1'b0}};
         rr_last_r   <= RR_RESET;
         gnt_idx_r   <= {GNT_W{1'b0}};
         bank_req_r  <= 1'b0;
         bank_addr_r <= {ADDR_W{1'b0}};
         rsp_ack_r   <= {N_REQ{1'b0}};
         rsp_err_r   <= 1'b0;
         rsp_data_r  <= {DATA_W{1'b0}};
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         cnt_r       <= cnt_nxt_s;
         rr_last_r   <= rr_last_nxt_s;
         gnt_idx_r   <= gnt_idx_nxt_s;
         bank_req_r  <= bank_req_nxt_s;
         bank_addr_r <= bank_addr_nxt_s;
         rsp_ack_r   <= rsp_ack_nxt_s;
         rsp_err_r   <= rsp_err_nxt_s;
         rsp_data_r  <= rsp_data_nxt_s;
         busy_r      <= busy_nxt_s;
      end
   end

   assign bus.Rsp_Ack   = rsp_ack_r;
   assign bus.Rsp_Err   = rsp_err_r;
   assign bus.Rsp_Data  = rsp_data_r;
   assign bus.Bank_Req  = bank_req_r;
   assign bus.Bank_Addr = bank_addr_r;
   assign bus.Busy      = busy_r;
   assign bus.Gnt_Idx   = gnt_idx_r;

endmodule

// File: tb/tb_cache_bank_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cache_bank_rr_arbiter
// Self-checking bench: requesters and bank are driven from the bench, and a
// transaction-level reference model (round-robin pointer plus bank data
// captured by the bench) supplies every expected value.
// ---------------------------------------------------------------------------
module tb_cache_bank_rr_arbiter;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 8;

   logic CLK  = 1'b0;
   logic RSTn = 1'b0;

   int checks_n = 0;
   int errors_n = 0;

   int          rr_last_m;
   logic [AW-1:0] addr_m [N];

   always #5 CLK = ~CLK;

   cache_bank_rr_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

   cache_bank_rr_arbiter #(
      .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
   ) dut (
      .CLK  (CLK),
      .RSTn (RSTn),
      .bus  (bus.slave)
   );

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks_n++;
      if (obs !== exp) begin
         errors_n++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and sample away from the edge.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Reference arbitration: first requester after the last winner, with wrap.
   function automatic int model_pick(input logic [N-1:0] req);
      for (int k = 1; k <= N; k++) begin
         if (req[(rr_last_m + k) % N]) return (rr_last_m + k) % N;
      end
      return -1;
   endfunction

   task automatic set_addr(input int i, input logic [AW-1:0] a);
      addr_m[i] = a;
      bus.Req_Addr[i*AW +: AW] = a;
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_rsp_ack"},   bus.Rsp_Ack,   0);
      check_val({tag, "_rsp_err"},   bus.Rsp_Err,   0);
      check_val({tag, "_rsp_data"},  bus.Rsp_Data,  0);
      check_val({tag, "_bank_req"},  bus.Bank_Req,  0);
      check_val({tag, "_bank_addr"}, bus.Bank_Addr, 0);
      check_val({tag, "_busy"},      bus.Busy,      0);
      check_val({tag, "_gnt_idx"},   bus.Gnt_Idx,   0);
   endtask

   // One full transaction starting from IDLE with Req already set.
   // d = bank delay (edges from its Bank_Req sample); d = 0 means no Ack.
   // hold keeps the winner's Req high after its Ack; pulse drops all Req after the grant edge.
   task automatic run_txn(input int d, input logic [DW-1:0] data, input bit hold, input bit pulse);
      int            w;
      int            lat;
      logic [N-1:0]  oh;
      logic [DW-1:0] exp_data;
      w = model_pick(bus.Req);
      if (w < 0) begin
         check_val("model_no_request", 0, 1);
         return;
      end
      oh       = N'(1) << w;
      exp_data = (d == 0) ? {DW{1'b0}} : data;
      step();                                    // grant edge E
      if (pulse) bus.Req = '0;
      check_val("bank_req_rise", bus.Bank_Req,  1);
      check_val("grant_idx",     bus.Gnt_Idx,   w);
      check_val("bank_addr",     bus.Bank_Addr, addr_m[w]);
      check_val("busy_wait",     bus.Busy,      1);
      rr_last_m = w;
      step();                                    // bank samples Bank_Req
      lat = 1;
      check_val("bank_req_fall", bus.Bank_Req, 0);
      if (d > 0) begin
         repeat (d) begin
            check_val("rsp_ack_early", bus.Rsp_Ack, 0);
            step();
         end
         bus.Bank_Ack  = 1'b1;
         bus.Bank_Data = data;
         step();
         bus.Bank_Ack  = 1'b0;
         bus.Bank_Data = $urandom;
      end else begin
         while (bus.Rsp_Ack == '0 && lat < 3*TO) begin
            step();
            lat++;
         end
         check_val("timeout_latency", lat, TO);
      end
      check_val("rsp_ack",      bus.Rsp_Ack,  oh);
      check_val("rsp_err",      bus.Rsp_Err,  (d == 0));
      check_val("rsp_data",     bus.Rsp_Data, exp_data);
      check_val("rsp_gnt_idx",  bus.Gnt_Idx,  w);
      check_val("busy_done",    bus.Busy,     1);
      if (!hold) bus.Req = bus.Req & ~oh;
      step();                                    // DONE -> IDLE
      check_val("rsp_ack_fall",  bus.Rsp_Ack,  0);
      check_val("rsp_err_fall",  bus.Rsp_Err,  0);
      check_val("rsp_data_hold", bus.Rsp_Data, exp_data);
      check_val("busy_idle",     bus.Busy,     0);
   endtask

   task automatic apply_reset();
      RSTn = 1'b0;
      step();
      RSTn = 1'b1;
      rr_last_m = N - 1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      bus.Req       = '0;
      bus.Req_Addr  = '0;
      bus.Bank_Ack  = 1'b0;
      bus.Bank_Data = '0;
      for (int i = 0; i < N; i++) addr_m[i] = '0;
      rr_last_m = N - 1;
      RSTn = 1'b0;
      repeat (2) step();
      check_all_zero("reset");
      RSTn = 1'b1;

      // Single requester, minimum bank delay.
      set_addr(1, 32'h0000_0100);
      bus.Req = 4'b0010;
      run_txn(1, 32'hDEAD_BEEF, 1'b0, 1'b0);

      // All requesters right after reset: order follows the pointer from 0.
      apply_reset();
      for (int i = 0; i < N; i++) set_addr(i, $urandom);
      bus.Req = 4'b1111;
      repeat (N) run_txn($urandom_range(1, 3), $urandom, 1'b0, 1'b0);
      repeat (3) begin
         step();
         check_val("idle_bank_req", bus.Bank_Req, 0);
         check_val("idle_busy",     bus.Busy,     0);
      end

      // Two requesters holding Req continuously must alternate.
      set_addr(0, $urandom);
      set_addr(2, $urandom);
      bus.Req = 4'b0101;
      repeat (6) run_txn($urandom_range(1, 3), $urandom, 1'b1, 1'b0);
      bus.Req = '0;

      // Bank never answers: timeout error, then a stray Ack is ignored.
      set_addr(2, $urandom);
      bus.Req = 4'b0100;
      run_txn(0, '0, 1'b0, 1'b0);
      step();
      bus.Bank_Ack  = 1'b1;
      bus.Bank_Data = $urandom;
      step();
      bus.Bank_Ack  = 1'b0;
      check_val("stray_ack_busy",    bus.Busy,     0);
      check_val("stray_ack_rsp",     bus.Rsp_Ack,  0);
      check_val("stray_ack_bankreq", bus.Bank_Req, 0);
      step();
      check_val("stray_ack_rsp2",    bus.Rsp_Ack,  0);
      check_val("stray_ack_busy2",   bus.Busy,     0);

      // Asynchronous reset in the middle of a wait for requester 3.
      set_addr(3, 32'hC0DE_0003);
      bus.Req = 4'b1000;
      step();
      check_val("rst_case_grant", bus.Gnt_Idx,   3);
      check_val("rst_case_addr",  bus.Bank_Addr, 32'hC0DE_0003);
      step();
      step();
      #2;
      RSTn = 1'b0;
      #1;
      check_all_zero("async_reset");
      step();
      bus.Req = 4'b1001;
      set_addr(0, $urandom);
      RSTn = 1'b1;
      rr_last_m = N - 1;
      run_txn(2, $urandom, 1'b0, 1'b0);
      run_txn(1, $urandom, 1'b0, 1'b0);

      // Request held for only one cycle is still served exactly once.
      set_addr(1, $urandom);
      bus.Req = 4'b0010;
      run_txn(1, $urandom, 1'b0, 1'b1);
      repeat (4) begin
         step();
         check_val("pulse_no_rereq", bus.Bank_Req, 0);
         check_val("pulse_no_rsp",   bus.Rsp_Ack,  0);
         check_val("pulse_idle",     bus.Busy,     0);
      end

      $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
      $finish;
   end

endmodule
